// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep stage.
// Vector index idx = {in1,in2,in3}; its observed output lands at table bit 7-idx.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_e;

    localparam int unsigned TT_W        = 8;
    localparam int unsigned NUM_VEC     = 8;
    localparam int unsigned SYNC_STAGES = 2;

    function automatic logic [2:0] tt_bit(input logic [2:0] idx);
        return 3'd7 - idx;
    endfunction

endpackage

// File: rtl/truth_table_sweep_sync2.sv
// Multi-flop synchronizer with synchronous active-high reset.
// The depth is SYNC_STAGES (two), so q lags d by two rising edges.
module sync2
    import tt_sweep_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] shreg_q;
    logic [SYNC_STAGES-1:0] shreg_d;

    always_comb begin
        shreg_d = {shreg_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign q = shreg_q[SYNC_STAGES-1];

endmodule

// File: rtl/truth_table_sweep.sv
// Drives a 3-input gate through all eight input vectors, holds each for
// SETTLE_CYCLES cycles and captures the synchronized response into table_q.
module truth_table_sweep
    import tt_sweep_pkg::*;
#(
    parameter int unsigned     SETTLE_CYCLES = 4,
    parameter logic [TT_W-1:0] EXPECTED      = 8'hEA
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            dut_out,
    output logic            in1,
    output logic            in2,
    output logic            in3,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] table_q,
    output logic            match,
    output logic [TT_W-1:0] mismatch_mask
);

    localparam int unsigned    CNT_W    = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0]     IDX_LAST = 3'(NUM_VEC - 1);

    state_e            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TT_W-1:0]   table_d;
    logic              match_q, match_d;
    logic [TT_W-1:0]   mask_q, mask_d;
    logic              dut_sync;

    sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (dut_out),
        .q     (dut_sync)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        match_d = match_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    table_d = '0;
                    match_d = 1'b0;
                    mask_d  = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    table_d[tt_bit(idx_q)] = dut_sync;
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        // Compare against the table including the final capture
                        // so match/mask are already valid during the done pulse.
                        match_d = (table_d == EXPECTED);
                        mask_d  = table_d ^ EXPECTED;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            table_q <= '0;
            match_q <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            match_q <= match_d;
            mask_q  <= mask_d;
        end
    end

    assign busy          = (state_q == APPLY);
    assign done          = (state_q == DONE);
    assign in1           = busy & idx_q[2];
    assign in2           = busy & idx_q[1];
    assign in3           = busy & idx_q[0];
    assign match         = match_q;
    assign mismatch_mask = mask_q;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Scoreboard bench: instance A (default settle) against an ideal or stuck gate,
// instance B (settle 5) against a 0xEA gate with a two-cycle output delay.
module tb_truth_table_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start_a, start_b;
    logic       dout_a, dout_b;
    logic       a_in1, a_in2, a_in3, a_busy, a_done, a_match;
    logic [7:0] a_table, a_mask;
    logic       b_in1, b_in2, b_in3, b_busy, b_done, b_match;
    logic [7:0] b_table, b_mask;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int spurious_a = 0;
    int spurious_b = 0;
    int c0_a = 0;
    int c0_b = 0;
    int gate_mode = 0;

    typedef struct {
        logic [7:0] tbl;
        logic       m;
        logic [7:0] mask;
        int         done_cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // 0xEA written as a gate equation: out = ~in3 | (~in1 & ~in2)
    function automatic logic ea_gate(input logic a, input logic b, input logic c);
        return ~c | (~a & ~b);
    endfunction

    assign dout_a = (gate_mode == 1) ? 1'b1 : ea_gate(a_in1, a_in2, a_in3);

    logic dly1 = 1'b0;
    logic dly2 = 1'b0;
    always @(posedge clk) begin
        dly1 <= ea_gate(b_in1, b_in2, b_in3);
        dly2 <= dly1;
    end
    assign dout_b = dly2;

    truth_table_sweep u_a (
        .clk(clk), .reset(reset), .start(start_a), .dut_out(dout_a),
        .in1(a_in1), .in2(a_in2), .in3(a_in3), .busy(a_busy), .done(a_done),
        .table_q(a_table), .match(a_match), .mismatch_mask(a_mask)
    );

    truth_table_sweep #(.SETTLE_CYCLES(5), .EXPECTED(8'hEA)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .dut_out(dout_b),
        .in1(b_in1), .in2(b_in2), .in3(b_in3), .busy(b_busy), .done(b_done),
        .table_q(b_table), .match(b_match), .mismatch_mask(b_mask)
    );

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (a_done === 1'b1) begin
            if (q_a.size() == 0) begin
                spurious_a++;
            end else begin
                e = q_a.pop_front();
                chk("a_table", a_table, e.tbl);
                chk("a_match", a_match, e.m);
                chk("a_mask", a_mask, e.mask);
                chk("a_done_cycle", cyc - c0_a + 1, e.done_cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_done === 1'b1) begin
            if (q_b.size() == 0) begin
                spurious_b++;
            end else begin
                e = q_b.pop_front();
                chk("b_table", b_table, e.tbl);
                chk("b_match", b_match, e.m);
                chk("b_mask", b_mask, e.mask);
                chk("b_done_cycle", cyc - c0_b + 1, e.done_cyc);
            end
        end
    end

    task automatic pulse_a(input exp_t e);
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        c0_a = cyc;
        q_a.push_back(e);
    endtask

    task automatic wait_a(input int budget);
        int n = 0;
        while (q_a.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("a_sweep_timeout", q_a.size(), 0);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; gate_mode = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_vec", {a_in1, a_in2, a_in3}, 0);
        chk("rst_table", a_table, 0);
        chk("rst_match", a_match, 0);
        chk("rst_mask", a_mask, 0);
        chk("rst_b_mask", b_mask, 0);
        reset = 1'b0;

        // Delayed gate, settle 5
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        c0_b = cyc;
        e = '{tbl: 8'hEA, m: 1'b1, mask: 8'h00, done_cyc: 41};
        q_b.push_back(e);
        begin
            int n = 0;
            while (q_b.size() != 0 && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("b_sweep_timeout", q_b.size(), 0);
        end
        @(negedge clk);

        // Ideal gate with per-cycle vector/busy/done checks and an ignored re-start
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        c0_a = cyc;
        e = '{tbl: 8'hEA, m: 1'b1, mask: 8'h00, done_cyc: 33};
        q_a.push_back(e);
        for (int k = 1; k <= 34; k++) begin
            if (k > 1) @(negedge clk);
            start_a = (k == 10);
            chk($sformatf("seq_busy_c%0d", k), a_busy, (k <= 32) ? 1 : 0);
            chk($sformatf("seq_vec_c%0d", k), {a_in1, a_in2, a_in3}, (k <= 32) ? (k - 1) / 4 : 0);
            chk($sformatf("seq_done_c%0d", k), a_done, (k == 33) ? 1 : 0);
            if (k == 5) chk("match_in_sweep", a_match, 0);
        end
        start_a = 1'b0;
        chk("seq_queue_empty", q_a.size(), 0);
        repeat (3) @(negedge clk);
        chk("hold_table", a_table, 8'hEA);
        chk("hold_match", a_match, 1);

        // Stuck-at-1 gate
        gate_mode = 1;
        pulse_a('{tbl: 8'hFF, m: 1'b0, mask: 8'h15, done_cyc: 33});
        wait_a(60);
        repeat (2) @(negedge clk);
        chk("stuck_hold_mask", a_mask, 8'h15);
        gate_mode = 0;

        // Reset while idx = 3, partial table discarded, then a clean sweep
        pulse_a('{tbl: 8'hEA, m: 1'b1, mask: 8'h00, done_cyc: 33});
        repeat (13) @(negedge clk);
        chk("mid_vec_before", {a_in1, a_in2, a_in3}, 3);
        chk("mid_partial_table", a_table, 8'hE0);
        reset = 1'b1;
        q_a.delete();
        @(negedge clk) reset = 1'b0;
        chk("mid_busy", a_busy, 0);
        chk("mid_vec", {a_in1, a_in2, a_in3}, 0);
        chk("mid_table", a_table, 0);
        chk("mid_match", a_match, 0);
        pulse_a('{tbl: 8'hEA, m: 1'b1, mask: 8'h00, done_cyc: 33});
        wait_a(60);
        @(negedge clk);

        // reset and start together
        reset = 1'b1; start_a = 1'b1;
        @(negedge clk) begin reset = 1'b0; start_a = 1'b0; end
        chk("coll_busy", a_busy, 0);
        chk("coll_vec", {a_in1, a_in2, a_in3}, 0);
        chk("coll_table", a_table, 0);
        repeat (40) @(negedge clk);
        chk("coll_busy_later", a_busy, 0);

        chk("a_spurious_done", spurious_a, 0);
        chk("b_spurious_done", spurious_b, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
